// File: rtl/ifm_sweep_gen.sv
// Producer side of the IFM window-buffer word protocol: sweeps a 3x3 window
// over the feature map along a snake path and emits one command word per read.
module ifm_sweep_gen #(
  parameter int         IFM_H      = 16,
  parameter int         IFM_W      = 16,
  parameter int         ADDR_WIDTH = 16,
  parameter logic [7:0] OP_ALL     = 8'h00,
  parameter logic [7:0] OP_RIGHT   = 8'h01,
  parameter logic [7:0] OP_LEFT    = 8'h02,
  parameter logic [7:0] OP_DOWN    = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr0,
  output logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic [7:0]            rd_data0,
  input  logic [7:0]            rd_data1,
  input  logic [7:0]            rd_data2,
  output logic [31:0]           ifm_word,
  output logic                  ifm_valid,
  output logic                  win_valid,
  output logic [7:0]            win_row,
  output logic [7:0]            win_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, MOVE, DRAIN} state_e;

  localparam logic [7:0]            LAST_R = 8'(IFM_H - 3);
  localparam logic [7:0]            LAST_C = 8'(IFM_W - 3);
  localparam logic [ADDR_WIDTH-1:0] W_A    = ADDR_WIDTH'(IFM_W);

  state_e     state_q;
  logic       busy_q;
  logic [7:0] r_q, c_q;
  logic       dir_q;
  logic [1:0] cnt_q;

  logic [7:0]            r_d, c_d;
  logic                  dir_d;
  logic [7:0]            op_d;
  logic                  win_d, eor, eor_d, last_d;
  logic [ADDR_WIDTH-1:0] addr0, addr1, addr2;

  // First pipeline stage: travels with the read, aligned with rd_data.
  logic       ifm_valid_q;
  logic [7:0] op_q;
  logic       win_p_q, last_p_q;
  logic [7:0] row_p_q, col_p_q;

  // Second stage: window report, one cycle behind the word.
  logic       win_valid_q, done_q;
  logic [7:0] win_row_q, win_col_q;

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [7:0] row,
                                                     input logic [7:0] col);
    return ADDR_WIDTH'(row) * W_A + ADDR_WIDTH'(col);
  endfunction

  assign eor = (!dir_q && c_q == LAST_C) || (dir_q && c_q == 8'd0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    op_d  = OP_ALL;
    r_d   = r_q;
    c_d   = c_q;
    dir_d = dir_q;
    win_d = 1'b0;
    addr0 = '0;
    addr1 = '0;
    addr2 = '0;
    case (state_q)
      LOAD: begin
        addr0 = pix_addr(8'd0, {6'd0, cnt_q});
        addr1 = pix_addr(8'd1, {6'd0, cnt_q});
        addr2 = pix_addr(8'd2, {6'd0, cnt_q});
        win_d = (cnt_q == 2'd2);
      end
      MOVE: begin
        win_d = 1'b1;
        if (!eor && !dir_q) begin
          op_d  = OP_RIGHT;
          addr0 = pix_addr(r_q,        c_q + 8'd3);
          addr1 = pix_addr(r_q + 8'd1, c_q + 8'd3);
          addr2 = pix_addr(r_q + 8'd2, c_q + 8'd3);
          c_d   = c_q + 8'd1;
        end else if (!eor) begin
          op_d  = OP_LEFT;
          addr0 = pix_addr(r_q,        c_q - 8'd1);
          addr1 = pix_addr(r_q + 8'd1, c_q - 8'd1);
          addr2 = pix_addr(r_q + 8'd2, c_q - 8'd1);
          c_d   = c_q - 8'd1;
        end else begin
          op_d  = OP_DOWN;
          addr0 = pix_addr(r_q + 8'd3, c_q);
          addr1 = pix_addr(r_q + 8'd3, c_q + 8'd1);
          addr2 = pix_addr(r_q + 8'd3, c_q + 8'd2);
          r_d   = r_q + 8'd1;
          dir_d = !dir_q;
        end
      end
      default: ;
    endcase
    // The window after this read is the last one when it sits on the bottom
    // band and at the end of its row in the post-move direction.
    eor_d  = (!dir_d && c_d == LAST_C) || (dir_d && c_d == 8'd0);
    last_d = win_d && (r_d == LAST_R) && eor_d;
  end

  assign rd_en    = ((state_q == LOAD) || (state_q == MOVE)) && !hold;
  assign rd_addr0 = rd_en ? addr0 : '0;
  assign rd_addr1 = rd_en ? addr1 : '0;
  assign rd_addr2 = rd_en ? addr2 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      r_q     <= 8'd0;
      c_q     <= 8'd0;
      dir_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
          r_q     <= 8'd0;
          c_q     <= 8'd0;
          dir_q   <= 1'b0;
          cnt_q   <= 2'd0;
        end
        LOAD: if (!hold) begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd2) state_q <= last_d ? DRAIN : MOVE;
        end
        MOVE: if (!hold) begin
          r_q   <= r_d;
          c_q   <= c_d;
          dir_q <= dir_d;
          if (last_d) state_q <= DRAIN;
        end
        DRAIN: if (done_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_valid_q <= 1'b0;
      op_q        <= 8'd0;
      win_p_q     <= 1'b0;
      last_p_q    <= 1'b0;
      row_p_q     <= 8'd0;
      col_p_q     <= 8'd0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
      win_row_q   <= 8'd0;
      win_col_q   <= 8'd0;
    end else begin
      ifm_valid_q <= rd_en;
      if (rd_en) begin
        op_q     <= op_d;
        win_p_q  <= win_d;
        last_p_q <= last_d;
        row_p_q  <= r_d;
        col_p_q  <= c_d;
      end
      win_valid_q <= ifm_valid_q && win_p_q;
      done_q      <= ifm_valid_q && win_p_q && last_p_q;
      if (ifm_valid_q && win_p_q) begin
        win_row_q <= row_p_q;
        win_col_q <= col_p_q;
      end
    end
  end

  // Read data is only valid alongside ifm_valid; the word is zero otherwise.
  assign ifm_word  = ifm_valid_q ? {op_q, rd_data0, rd_data1, rd_data2} : 32'd0;
  assign ifm_valid = ifm_valid_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ifm_sweep_gen.sv
// Bench for ifm_sweep_gen: three instances (5x5, 3x3, 6x3) checked every cycle
// against a snake-path model derived from the window sequence.
`timescale 1ns/1ps
module tb_ifm_sweep_gen;
  localparam int ND   = 3;
  localparam int AW   = 16;
  localparam int MAXN = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_a [ND];
  logic          hold_a  [ND];
  logic          rd_en_a [ND];
  logic [AW-1:0] a0_a [ND], a1_a [ND], a2_a [ND];
  logic [7:0]    d0_a [ND], d1_a [ND], d2_a [ND];
  logic [31:0]   word_a [ND];
  logic          iv_a [ND], wv_a [ND], busy_a [ND], done_a [ND];
  logic [7:0]    wr_a [ND], wc_a [ND];

  always #5 clk = ~clk;

  ifm_sweep_gen #(.IFM_H(5), .IFM_W(5), .ADDR_WIDTH(AW)) u_dut5x5 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .hold(hold_a[0]),
    .rd_en(rd_en_a[0]), .rd_addr0(a0_a[0]), .rd_addr1(a1_a[0]), .rd_addr2(a2_a[0]),
    .rd_data0(d0_a[0]), .rd_data1(d1_a[0]), .rd_data2(d2_a[0]),
    .ifm_word(word_a[0]), .ifm_valid(iv_a[0]), .win_valid(wv_a[0]),
    .win_row(wr_a[0]), .win_col(wc_a[0]), .busy(busy_a[0]), .done(done_a[0]));

  ifm_sweep_gen #(.IFM_H(3), .IFM_W(3), .ADDR_WIDTH(AW)) u_dut3x3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .hold(hold_a[1]),
    .rd_en(rd_en_a[1]), .rd_addr0(a0_a[1]), .rd_addr1(a1_a[1]), .rd_addr2(a2_a[1]),
    .rd_data0(d0_a[1]), .rd_data1(d1_a[1]), .rd_data2(d2_a[1]),
    .ifm_word(word_a[1]), .ifm_valid(iv_a[1]), .win_valid(wv_a[1]),
    .win_row(wr_a[1]), .win_col(wc_a[1]), .busy(busy_a[1]), .done(done_a[1]));

  ifm_sweep_gen #(.IFM_H(6), .IFM_W(3), .ADDR_WIDTH(AW)) u_dut6x3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .hold(hold_a[2]),
    .rd_en(rd_en_a[2]), .rd_addr0(a0_a[2]), .rd_addr1(a1_a[2]), .rd_addr2(a2_a[2]),
    .rd_data0(d0_a[2]), .rd_data1(d1_a[2]), .rd_data2(d2_a[2]),
    .ifm_word(word_a[2]), .ifm_valid(iv_a[2]), .win_valid(wv_a[2]),
    .win_row(wr_a[2]), .win_col(wc_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  // Synchronous pixel memory, pixel[a] = a (low byte), one-cycle latency.
  always @(posedge clk)
    for (int d = 0; d < ND; d++)
      if (rd_en_a[d]) begin
        d0_a[d] <= a0_a[d][7:0];
        d1_a[d] <= a1_a[d][7:0];
        d2_a[d] <= a2_a[d][7:0];
      end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected words and windows per instance.
  logic [31:0] ew   [ND][MAXN];
  int          wr_m [ND][MAXN];
  int          wc_m [ND][MAXN];
  int          nw   [ND];
  int          nwin [ND];

  function automatic logic [7:0] pix(input int r, input int c, input int w);
    int a;
    a = r * w + c;
    return a[7:0];
  endfunction

  task automatic build(input int d, input int h, input int w);
    int r, c, pr, pc;
    nwin[d] = 0;
    for (r = 0; r <= h - 3; r++)
      for (int k = 0; k <= w - 3; k++) begin
        c = (r % 2 == 0) ? k : (w - 3 - k);
        wr_m[d][nwin[d]] = r;
        wc_m[d][nwin[d]] = c;
        nwin[d]++;
      end
    nw[d] = 0;
    for (c = 0; c < 3; c++) begin
      ew[d][nw[d]] = {8'h00, pix(0, c, w), pix(1, c, w), pix(2, c, w)};
      nw[d]++;
    end
    for (int k = 1; k < nwin[d]; k++) begin
      pr = wr_m[d][k-1]; pc = wc_m[d][k-1];
      r  = wr_m[d][k];   c  = wc_m[d][k];
      if (r > pr)
        ew[d][nw[d]] = {8'hFF, pix(r + 2, c, w), pix(r + 2, c + 1, w), pix(r + 2, c + 2, w)};
      else if (c > pc)
        ew[d][nw[d]] = {8'h01, pix(r, c + 2, w), pix(r + 1, c + 2, w), pix(r + 2, c + 2, w)};
      else
        ew[d][nw[d]] = {8'h02, pix(r, c, w), pix(r + 1, c, w), pix(r + 2, c, w)};
      nw[d]++;
    end
  endtask

  // Per-cycle compare process.
  int wi [ND];
  int pidx [ND];
  bit pv [ND];
  bit pdone [ND];
  int frames [ND];

  initial for (int d = 0; d < ND; d++) begin
    wi[d] = 0; pidx[d] = 0; pv[d] = 0; pdone[d] = 0; frames[d] = 0;
  end

  always @(negedge clk) begin
    bit exp_win, exp_done;
    int wk;
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) begin
        wi[d] = 0; pv[d] = 0; pdone[d] = 0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (hold_a[d]) check($sformatf("rd_en_in_hold[%0d]", d), rd_en_a[d], 1'b0);
        exp_win  = pv[d] && (pidx[d] >= 2);
        wk       = pidx[d] - 2;
        exp_done = exp_win && (wk == nwin[d] - 1);
        check($sformatf("win_valid[%0d]", d), wv_a[d], exp_win);
        check($sformatf("done[%0d]", d), done_a[d], exp_done);
        if (exp_win && wv_a[d] && wk < nwin[d]) begin
          check($sformatf("win_row[%0d]", d), wr_a[d], wr_m[d][wk]);
          check($sformatf("win_col[%0d]", d), wc_a[d], wc_m[d][wk]);
        end
        if (pdone[d]) check($sformatf("busy_after_done[%0d]", d), busy_a[d], 1'b0);
        if (iv_a[d]) begin
          check($sformatf("word_in_range[%0d]", d), wi[d] < nw[d], 1'b1);
          if (wi[d] < nw[d])
            check($sformatf("word%0d[%0d]", wi[d], d), word_a[d], ew[d][wi[d]]);
          pidx[d] = wi[d];
          wi[d]++;
        end
        pv[d] = iv_a[d];
        if (done_a[d]) begin
          check($sformatf("word_count[%0d]", d), wi[d], nw[d]);
          wi[d] = 0;
          frames[d]++;
        end
        pdone[d] = done_a[d];
      end
    end
  end

  // Starts one frame on instance d; cyc = cycles from acceptance to done.
  task automatic run_frame(input int d, input int hold_at, output int cyc);
    bit seen;
    int f0;
    seen = 0; cyc = 0; f0 = frames[d];
    @(posedge clk); #1 start_a[d] = 1'b1;
    @(posedge clk); #1 start_a[d] = 1'b0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      hold_a[d] = (hold_at > 0 && k >= hold_at && k < hold_at + 4);
      @(negedge clk);
      if (k == 1) check($sformatf("busy_after_start[%0d]", d), busy_a[d], 1'b1);
      if (done_a[d]) begin
        seen = 1; cyc = k;
      end else begin
        @(posedge clk); #1;
      end
    end
    hold_a[d] = 1'b0;
    check($sformatf("frame_done_seen[%0d]", d), seen, 1'b1);
    @(posedge clk); #1;
    check($sformatf("frame_count[%0d]", d), frames[d], f0 + 1);
  endtask

  task automatic wait_done(input int d, output bit seen);
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done_a[d]) seen = 1;
    end
  endtask

  initial begin
    int  c_nohold, c, cnt, f0;
    bit  seen;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      start_a[d] = 1'b0; hold_a[d] = 1'b0;
    end
    build(0, 5, 5);
    build(1, 3, 3);
    build(2, 6, 3);

    // Hand-computed expectations pinning the model.
    check("model_nw5x5", nw[0], 11);
    check("model_nwin5x5", nwin[0], 9);
    check("model_w0", ew[0][0], 32'h0000050A);
    check("model_w1", ew[0][1], 32'h0001060B);
    check("model_w3", ew[0][3], 32'h0103080D);
    check("model_w5", ew[0][5], 32'hFF111213);
    check("model_w6", ew[0][6], 32'h02060B10);
    check("model_w7", ew[0][7], 32'h02050A0F);
    check("model_w8", ew[0][8], 32'hFF141516);
    check("model_w10", ew[0][10], 32'h010E1318);
    check("model_win5", {wr_m[0][5][7:0], wc_m[0][5][7:0]}, 16'h0100);
    check("model_3x3_w2", ew[1][2], 32'h00020508);
    check("model_nw6x3", nw[2], 6);
    check("model_6x3_w3", ew[2][3], 32'hFF090A0B);
    check("model_6x3_w5", ew[2][5], 32'hFF0F1011);
    check("model_nwin6x3", nwin[2], 4);

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      check($sformatf("reset_outputs[%0d]", d),
            {rd_en_a[d], iv_a[d], wv_a[d], done_a[d], busy_a[d]}, 5'd0);
    rst_n = 1'b1;

    run_frame(0, -1, c_nohold);
    check("cycles_5x5", c_nohold, 13);
    run_frame(1, -1, c);
    check("cycles_3x3", c, 5);
    run_frame(2, -1, c);
    check("cycles_6x3", c, 8);

    // Four-cycle hold in the first row: same words, four cycles later.
    run_frame(0, 5, c);
    check("cycles_with_hold", c, c_nohold + 4);

    // Reset in the middle of MOVE.
    @(posedge clk); #1 start_a[0] = 1'b1;
    @(posedge clk); #1 start_a[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ctrl", {rd_en_a[0], iv_a[0], wv_a[0], done_a[0], busy_a[0]}, 5'd0);
    check("rst_word", word_a[0], 32'd0);
    check("rst_win", {wr_a[0], wc_a[0]}, 16'd0);
    check("rst_addr", a0_a[0] | a1_a[0] | a2_a[0], 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (iv_a[0] || rd_en_a[0]) cnt++;
    end
    check("quiet_after_reset", cnt, 0);
    run_frame(0, -1, c);
    check("cycles_after_reset", c, 13);

    // start held high: one frame, then a new one right after IDLE.
    f0 = frames[0];
    @(posedge clk); #1 start_a[0] = 1'b1;
    wait_done(0, seen);
    check("held_start_done1", seen, 1'b1);
    @(negedge clk);
    check("held_start_idle_rd_en", rd_en_a[0], 1'b0);
    @(negedge clk);
    check("held_start_restart_rd_en", rd_en_a[0], 1'b1);
    check("held_start_restart_busy", busy_a[0], 1'b1);
    @(posedge clk); #1 start_a[0] = 1'b0;
    wait_done(0, seen);
    check("held_start_done2", seen, 1'b1);
    @(posedge clk); #1;
    check("held_start_frames", frames[0], f0 + 2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
